fifo_wr_rr_arbiter: RTL and testbench

//  Round-robin write arbiter that lets NUM_REQ producers share the write port of one fifo_8bit

---
 rtl/fifo_wr_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fifo_wr_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter
// Round-robin write arbiter letting NUM_REQ producers share the write port of a
// single FIFO. A granted producer owns the port for up to MAX_BURST beats, then
// ownership rotates, with the previous owner at lowest priority. Exactly one
// IDLE cycle separates consecutive grants.
module fifo_wr_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr,
    output logic [DATA_W-1:0]            fifo_din,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [$clog2(NUM_REQ)-1:0]   owner_id,
    output logic                         busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [3:0]    LAST_BEAT = 4'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]       last_q, last_d;

    logic                win_found_s;
    logic [OW-1:0]       win_idx_s;
    logic [OW-1:0]       scan_idx_s;
    logic                owner_valid_s;
    logic                beat_s;
    logic [DATA_W-1:0]   data_arr_s [NUM_REQ];

    // Split the flat producer data bus into one word per producer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Rotating priority scan starting just after the previous owner; the
    // previous owner is examined last so it only wins when it is alone.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (scan_idx_s == LAST_IDX) begin
                scan_idx_s = '0;
            end else begin
                scan_idx_s = scan_idx_s + OW'(1);
            end
            if (!win_found_s && req_valid[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // A beat moves only in OWN, with the owner valid, the FIFO not full and
    // reset not asserted (a beat in flight during reset is dropped).
    always_comb begin
        owner_valid_s = req_valid[owner_q];
        if (state_q == ST_OWN) begin
            beat_s = owner_valid_s & ~fifo_full & ~rst;
        end else begin
            beat_s = 1'b0;
        end
    end

    // Next-state logic: grant on request in IDLE, count beats and release in OWN.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d    = ST_OWN;
                    gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    owner_d    = win_idx_s;
                    beat_cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_valid_s || (beat_s && (beat_cnt_q == LAST_BEAT))) begin
                    state_d    = ST_IDLE;
                    last_d     = owner_q;
                    gnt_d      = '0;
                    owner_d    = '0;
                    beat_cnt_d = 4'd0;
                end else if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    // FIFO full: owner stalls, grant and count hold.
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                owner_d    = '0;
                beat_cnt_d = 4'd0;
                last_d     = LAST_IDX;
            end
        endcase
    end

    // State register with synchronous reset; producer 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            beat_cnt_q <= 4'd0;
            last_q     <= LAST_IDX;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    // Port-side outputs: ready follows the grant unless the FIFO is full or
    // reset is asserted; write data is zero whenever no beat moves.
    always_comb begin
        if ((state_q == ST_OWN) && !rst) begin
            req_ready = gnt_q & {NUM_REQ{~fifo_full}};
        end else begin
            req_ready = '0;
        end
        fifo_wr = beat_s;
        if (beat_s) begin
            fifo_din = data_arr_s[owner_q];
        end else begin
            fifo_din = '0;
        end
        gnt      = gnt_q;
        owner_id = owner_q;
        busy     = (state_q == ST_OWN);
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Directed and random checks of the round-robin FIFO write arbiter
// (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_wr_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;

    int n_chk;
    int n_fail;

    fifo_wr_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .gnt       (gnt),
        .owner_id  (owner_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int p, input int b);
        return 8'(8'hA1 + 16 * p + b);
    endfunction

    task automatic set_data(input int p, input logic [7:0] v);
        req_data[p*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Expect beats b0..b1-1 from producer p on consecutive cycles.
    task automatic burst(input int p, input int b0, input int b1, input string tag);
        for (int b = b0; b < b1; b++) begin
            set_data(p, dat(p, b));
            #1;
            chk($sformatf("%s_gnt%0d", tag, b), 32'(gnt), 32'(1 << p));
            chk($sformatf("%s_own%0d", tag, b), 32'(owner_id), 32'(p));
            chk($sformatf("%s_busy%0d", tag, b), 32'(busy), 32'd1);
            chk($sformatf("%s_rdy%0d", tag, b), 32'(req_ready), 32'(1 << p));
            chk($sformatf("%s_wr%0d", tag, b), 32'(fifo_wr), 32'd1);
            chk($sformatf("%s_din%0d", tag, b), 32'(fifo_din), 32'(dat(p, b)));
            tick();
        end
    endtask

    // Expect the single idle cycle between grants.
    task automatic bubble(input string tag);
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_own"}, 32'(owner_id), 32'd0);
        chk({tag, "_wr"}, 32'(fifo_wr), 32'd0);
        chk({tag, "_din"}, 32'(fifo_din), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
        tick();
    endtask

    logic [3:0] pend;
    logic [5:0] seq [4];
    logic [3:0] acc;
    int         bc;
    int         wp;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        fifo_full = 1'b0;

        // ---- 1: reset values, single producer burst and re-grant ----
        tick();
        req_valid = 4'b0001;
        set_data(0, dat(0, 0));
        #1;
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_own", 32'(owner_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("t1_idle_wr", 32'(fifo_wr), 32'd0);
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        tick();
        burst(0, 0, 4, "t1");
        set_data(0, dat(0, 4));
        bubble("t1_rel");
        #1;
        chk("t1_regnt", 32'(gnt), 32'b0001);

        // ---- 2: all four requesting, rotation 0,1,2,3,0 ----
        do_reset();
        req_valid = 4'b1111;
        for (int p = 0; p < 4; p++) set_data(p, dat(p, 0));
        #1;
        chk("t2_idle_gnt", 32'(gnt), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            burst(k % 4, 0, 4, $sformatf("t2_k%0d", k));
            if (k < 4) bubble($sformatf("t2_bub%0d", k));
        end

        // ---- 3: FIFO full stalls owner 2 mid-burst ----
        do_reset();
        req_valid = 4'b0100;
        set_data(2, dat(2, 0));
        tick();
        burst(2, 0, 1, "t3a");
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_data(2, dat(2, 1));
            #1;
            chk($sformatf("t3_full_wr%0d", c), 32'(fifo_wr), 32'd0);
            chk($sformatf("t3_full_rdy%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("t3_full_gnt%0d", c), 32'(gnt), 32'b0100);
            tick();
        end
        fifo_full = 1'b0;
        burst(2, 1, 4, "t3b");
        req_valid = 4'b0000;
        bubble("t3_rel");

        // ---- 4: owner 1 drops valid after 2 beats, producer 3 waiting ----
        do_reset();
        req_valid = 4'b1010;
        set_data(1, dat(1, 0));
        set_data(3, dat(3, 0));
        tick();
        burst(1, 0, 2, "t4");
        req_valid = 4'b1000;
        #1;
        chk("t4_drop_wr", 32'(fifo_wr), 32'd0);
        chk("t4_drop_gnt", 32'(gnt), 32'b0010);
        tick();
        chk("t4_bub_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t4_next_gnt", 32'(gnt), 32'b1000);
        chk("t4_next_own", 32'(owner_id), 32'd3);

        // ---- 5: reset during owner 0's second beat ----
        do_reset();
        req_valid = 4'b0001;
        set_data(0, dat(0, 0));
        tick();
        burst(0, 0, 1, "t5a");
        rst = 1'b1;
        set_data(0, dat(0, 1));
        #1;
        chk("t5_rst_wr", 32'(fifo_wr), 32'd0);
        chk("t5_rst_rdy", 32'(req_ready), 32'd0);
        tick();
        chk("t5_post_gnt", 32'(gnt), 32'd0);
        chk("t5_post_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int p = 0; p < 4; p++) set_data(p, dat(p, 0));
        tick();
        burst(0, 0, 4, "t5b");
        bubble("t5_rel");
        chk("t5_rot_gnt", 32'(gnt), 32'b0010);

        // ---- 6: random traffic with per-producer scoreboard ----
        do_reset();
        pend = 4'b0000;
        for (int p = 0; p < 4; p++) seq[p] = 6'd0;
        bc = 0;
        for (int cyc = 0; cyc < 10200; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                if (!pend[p] && (cyc < 10000) && ($urandom_range(0, 1) == 0)) begin
                    pend[p] = 1'b1;
                    set_data(p, {2'(p), seq[p]});
                end
            end
            req_valid = pend;
            fifo_full = (cyc < 10000) ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            chk("r_onehot", 32'($countones(gnt) <= 1), 32'd1);
            acc = req_valid & req_ready;
            chk("r_acc", 32'($countones(acc)), 32'(fifo_wr));
            if (gnt == 4'b0000) bc = 0;
            if (fifo_wr) begin
                chk("r_full", 32'(fifo_full), 32'd0);
                wp = 0;
                for (int p = 0; p < 4; p++) if (acc[p]) wp = p;
                chk("r_data", 32'(fifo_din), 32'({2'(wp), seq[wp]}));
                seq[wp] = seq[wp] + 6'd1;
                pend[wp] = 1'b0;
                bc++;
                chk("r_burst", 32'(bc <= 4), 32'd1);
            end
            tick();
        end
        chk("r_drain", 32'(pend), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
